// File: rtl/wrapper.sv
// Board I/O shell: synchronizes the DIP switches and runs an 18-step
// bit-analysis frame, publishing popcount / msb index / reversed bits.
module wrapper #(
    parameter int N_DIPs = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [N_DIPs-1:0] DIP,
    output logic [6:0]        LED_PC,
    output logic [31:0]       SEVENSEGHEX
);

    localparam logic [4:0] STEP_LATCH = 5'd0;
    localparam logic [4:0] STEP_WRITE = 5'd17;

    logic [4:0]        step;
    logic [4:0]        step_nxt;
    logic              is_latch;
    logic              is_bit;
    logic              is_write;
    logic [3:0]        k;
    logic              b;

    logic [N_DIPs-1:0] dip_s1;
    logic [N_DIPs-1:0] dip_s2;
    logic [N_DIPs-1:0] sample;
    logic [4:0]        pop;
    logic [4:0]        msb;
    logic [15:0]       rev;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            step <= STEP_LATCH;
        end else begin
            step <= step_nxt;
        end
    end

    always_comb begin
        step_nxt = step + 5'd1;
        if (step == STEP_WRITE) begin
            step_nxt = STEP_LATCH;
        end
    end

    always_comb begin
        is_latch = 1'b0;
        is_bit   = 1'b0;
        is_write = 1'b0;
        unique case (1'b1)
            (step == STEP_LATCH): is_latch = 1'b1;
            (step == STEP_WRITE): is_write = 1'b1;
            default:              is_bit   = 1'b1;
        endcase
    end

    // Bit position examined in a BIT step; only meaningful when is_bit.
    assign k = 4'(step - 5'd1);
    assign b = sample[k];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dip_s1 <= '0;
            dip_s2 <= '0;
        end else begin
            dip_s1 <= DIP;
            dip_s2 <= dip_s1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sample <= '0;
            pop    <= '0;
            msb    <= '0;
            rev    <= '0;
        end else if (is_latch) begin
            sample <= dip_s2;
            pop    <= '0;
            msb    <= '0;
            rev    <= '0;
        end else if (is_bit) begin
            pop <= pop + {4'd0, b};
            if (b) begin
                msb <= {1'b0, k} + 5'd1;
            end
            rev[~k] <= b;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SEVENSEGHEX <= '0;
        end else if (is_write) begin
            SEVENSEGHEX <= {3'b0, pop, 3'b0, msb, rev};
        end
    end

    assign LED_PC = {2'b00, step};

endmodule

// File: tb/tb_wrapper.sv
// Directed bench for wrapper: reset, step sequence, result words
// for several switch patterns, mid-frame DIP change and mid-frame reset.
module tb_wrapper;

    logic        CLK;
    logic        RESET;
    logic [15:0] DIP;
    logic [6:0]  LED_PC;
    logic [31:0] SEVENSEGHEX;

    int checks;
    int failures;

    wrapper #(.N_DIPs(16)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DIP        (DIP),
        .LED_PC     (LED_PC),
        .SEVENSEGHEX(SEVENSEGHEX)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_step(input logic [6:0] n);
        bit hit;
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (LED_PC == n) begin
                hit = 1;
                break;
            end
        end
        if (!hit) chk("wait_step_timeout", {25'd0, LED_PC}, {25'd0, n});
    endtask

    task automatic frame(input string tag, input logic [15:0] d,
                         input logic [31:0] exp);
        DIP = d;
        edges(40);
        chk(tag, SEVENSEGHEX, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        DIP      = 16'hFFFF;
        RESET    = 1'b1;
        #3;
        chk("rst_led", {25'd0, LED_PC}, 32'd0);
        chk("rst_hex", SEVENSEGHEX, 32'h0);
        edges(2);
        chk("rst_hold_led", {25'd0, LED_PC}, 32'd0);
        chk("rst_hold_hex", SEVENSEGHEX, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 1; i <= 18; i++) begin
            edges(1);
            chk($sformatf("seq_%0d", i), {25'd0, LED_PC}, 32'(i % 18));
        end

        frame("zero",   16'h0000, 32'h00000000);
        frame("mixed",  16'h05DB, 32'h080BDBA0);
        frame("top",    16'hA188, 32'h05101185);
        frame("all1",   16'hFFFF, 32'h1010FFFF);
        frame("bit0",   16'h0001, 32'h01018000);
        frame("bit15",  16'h8000, 32'h01100001);
        frame("mixed2", 16'h05DB, 32'h080BDBA0);

        wait_step(7'd8);
        DIP = 16'hA188;
        wait_step(7'd0);
        chk("mid_old", SEVENSEGHEX, 32'h080BDBA0);
        edges(17);
        chk("mid_hold", SEVENSEGHEX, 32'h080BDBA0);
        edges(1);
        chk("mid_new", SEVENSEGHEX, 32'h05101185);
        chk("mid_new_led", {25'd0, LED_PC}, 32'd0);

        wait_step(7'd10);
        RESET = 1'b1;
        #1;
        chk("mrst_hex", SEVENSEGHEX, 32'h0);
        chk("mrst_led", {25'd0, LED_PC}, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        edges(1);
        chk("mrst_first_led", {25'd0, LED_PC}, 32'd1);
        edges(16);
        chk("mrst_pre_led", {25'd0, LED_PC}, 32'd17);
        chk("mrst_pre_hex", SEVENSEGHEX, 32'h0);
        edges(1);
        chk("mrst_wr_led", {25'd0, LED_PC}, 32'd0);
        edges(18);
        chk("mrst_val", SEVENSEGHEX, 32'h05101185);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
